// File: rtl/scoreboard_pkg.sv
// Shared definitions for the score display: conversion FSM states, segment patterns,
// score limit and one-hot digit-enable codes.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } conv_state_t;

    localparam int MAX_SCORE = 99;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIGIT_ONES = 2'b01;
    localparam logic [1:0] DIGIT_TENS = 2'b10;

endpackage

// File: rtl/score_display_seg7_decoder.sv
// Combinational BCD to 7-segment decoder; any digit above 9 shows blank.
module seg7_decoder
    import scoreboard_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Binary score to two multiplexed 7-segment digits via a subtract-by-10 FSM.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens slot when the tens digit is 0.
module score_display
    import scoreboard_pkg::*;
#(
    parameter int BW          = 7,
    parameter int REFRESH_DIV = 1000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] value_i,
    output logic [3:0]    bcd_tens_o,
    output logic [3:0]    bcd_ones_o,
    output logic          valid_o,
    output logic [1:0]    digit_sel_o,
    output logic [6:0]    seg_o
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [BW-1:0] MAX_VAL  = BW'(MAX_SCORE);
    localparam logic [BW-1:0] TEN      = BW'(10);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    conv_state_t   r_state;
    conv_state_t   w_state_next;
    logic [BW-1:0] r_work;
    logic [BW-1:0] r_last;
    logic [3:0]    r_tens_acc;
    logic [3:0]    r_ones;
    logic          r_first;
    logic [3:0]    r_bcd_tens;
    logic [3:0]    r_bcd_ones;
    logic          r_valid;
    logic [CW-1:0] r_refresh;
    logic [1:0]    r_digit_sel;
    logic [6:0]    r_seg;

    logic          w_sample;
    logic          w_sub;
    logic          w_latch_ones;
    logic          w_commit;
    logic [BW-1:0] w_sat;
    logic [1:0]    w_next_sel;
    logic [3:0]    w_mux_digit;
    logic [6:0]    w_seg_dec;
    logic [6:0]    w_seg_next;

    assign w_sat = (value_i > MAX_VAL) ? MAX_VAL : value_i;

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_sub        = 1'b0;
        w_latch_ones = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_first || (value_i != r_last)) begin
                    w_sample     = 1'b1;
                    w_state_next = ST_DIV;
                end
            end
            ST_DIV: begin
                if (r_work >= TEN) begin
                    w_sub = 1'b1;
                end else begin
                    w_latch_ones = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_commit     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_work     <= '0;
            r_last     <= '0;
            r_tens_acc <= 4'd0;
            r_ones     <= 4'd0;
            r_first    <= 1'b1;
            r_bcd_tens <= 4'd0;
            r_bcd_ones <= 4'd0;
            r_valid    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_sample) begin
                r_work     <= w_sat;
                r_last     <= value_i;
                r_tens_acc <= 4'd0;
                r_first    <= 1'b0;
                r_valid    <= 1'b0;
            end
            if (w_sub) begin
                r_work     <= r_work - TEN;
                r_tens_acc <= r_tens_acc + 4'd1;
            end
            if (w_latch_ones) begin
                r_ones <= r_work[3:0];
            end
            if (w_commit) begin
                r_bcd_tens <= r_tens_acc;
                r_bcd_ones <= r_ones;
                r_valid    <= 1'b1;
            end
        end
    end

    // Decode the digit that becomes active on the wrap so seg and select move together.
    assign w_next_sel  = (r_digit_sel == DIGIT_ONES) ? DIGIT_TENS : DIGIT_ONES;
    assign w_mux_digit = (w_next_sel == DIGIT_TENS) ? r_bcd_tens : r_bcd_ones;

    seg7_decoder u_dec (
        .i_bcd (w_mux_digit),
        .o_seg (w_seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign w_seg_next = ((w_next_sel == DIGIT_TENS) && (r_bcd_tens == 4'd0)) ? SEG_BLANK : w_seg_dec;
`else
    assign w_seg_next = w_seg_dec;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_refresh   <= '0;
            r_digit_sel <= DIGIT_ONES;
            r_seg       <= SEG_BLANK;
        end else if (r_refresh == CNT_LAST) begin
            r_refresh   <= '0;
            r_digit_sel <= w_next_sel;
            r_seg       <= w_seg_next;
        end else begin
            r_refresh <= r_refresh + CW'(1);
        end
    end

    assign bcd_tens_o  = r_bcd_tens;
    assign bcd_ones_o  = r_bcd_ones;
    assign valid_o     = r_valid;
    assign digit_sel_o = r_digit_sel;
    assign seg_o       = r_seg;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display with a 4-cycle refresh divider.
// Expected tens-slot pattern for scores 0-9 follows LEADING_ZERO_BLANK_EN.
module tb_score_display;

    logic       clk_i;
    logic       rst_i;
    logic [6:0] value_i;
    logic [3:0] bcd_tens_o;
    logic [3:0] bcd_ones_o;
    logic       valid_o;
    logic [1:0] digit_sel_o;
    logic [6:0] seg_o;

    int checks;
    int failures;
    int seen45;

    score_display #(.BW(7), .REFRESH_DIV(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .value_i     (value_i),
        .bcd_tens_o  (bcd_tens_o),
        .bcd_ones_o  (bcd_ones_o),
        .valid_o     (valid_o),
        .digit_sel_o (digit_sel_o),
        .seg_o       (seg_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (valid_o === 1'b1 && bcd_tens_o === 4'd4 && bcd_ones_o === 4'd5) seen45 = 1;
    endtask

    task automatic applyStimulus(input logic [6:0] v, input logic r);
        value_i = v;
        rst_i   = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Ticks until valid_o is seen high; k is the tick count, 0 on timeout.
    task automatic waitValid(output int k);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (valid_o === 1'b1) begin
                k = i;
                break;
            end
        end
        if (k == 0) checkOutput("valid_timeout", 32'd0, 32'd1);
    endtask

    // Ticks until digit_sel_o newly becomes target.
    task automatic waitSelEdge(input logic [1:0] target);
        logic [1:0] prev;
        int ok;
        ok = 0;
        prev = digit_sel_o;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (prev !== target && digit_sel_o === target) begin
                ok = 1;
                break;
            end
            prev = digit_sel_o;
        end
        if (ok == 0) checkOutput("sel_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        int n;
        logic [6:0] segPrev;
        logic [6:0] expTensZero;
        checks   = 0;
        failures = 0;
        seen45   = 0;
`ifdef LEADING_ZERO_BLANK_EN
        expTensZero = 7'h00;
`else
        expTensZero = 7'h3F;
`endif

        applyStimulus(7'd0, 1'b1);
        tick();
        tick();
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_tens", 32'(bcd_tens_o), 32'd0);
        checkOutput("rst_ones", 32'(bcd_ones_o), 32'd0);
        checkOutput("rst_sel", 32'(digit_sel_o), 32'h1);
        checkOutput("rst_seg", 32'(seg_o), 32'h00);

        applyStimulus(7'd0, 1'b0);
        waitValid(k);
        checkOutput("zero_latency", 32'(k), 32'd3);
        checkOutput("zero_tens", 32'(bcd_tens_o), 32'd0);
        checkOutput("zero_ones", 32'(bcd_ones_o), 32'd0);
        waitSelEdge(2'b10);
        checkOutput("zero_tens_seg", 32'(seg_o), 32'(expTensZero));
        waitSelEdge(2'b01);
        checkOutput("zero_ones_seg", 32'(seg_o), 32'h3F);

        applyStimulus(7'd57, 1'b0);
        waitValid(k);
        checkOutput("v57_latency", 32'(k), 32'd8);
        checkOutput("v57_tens", 32'(bcd_tens_o), 32'd5);
        checkOutput("v57_ones", 32'(bcd_ones_o), 32'd7);
        waitSelEdge(2'b10);
        checkOutput("v57_tens_seg", 32'(seg_o), 32'h6D);
        waitSelEdge(2'b01);
        checkOutput("v57_ones_seg", 32'(seg_o), 32'h07);

        n = 0;
        segPrev = seg_o;
        for (int i = 1; i <= 10; i++) begin
            segPrev = seg_o;
            tick();
            if (digit_sel_o !== 2'b01) begin
                n = i;
                break;
            end
        end
        checkOutput("refresh_period", 32'(n), 32'd4);
        checkOutput("seg_before_flip", 32'(segPrev), 32'h07);
        checkOutput("seg_at_flip", 32'(seg_o), 32'h6D);
        checkOutput("sel_at_flip", 32'(digit_sel_o), 32'h2);

        applyStimulus(7'd99, 1'b0);
        waitValid(k);
        checkOutput("v99_latency", 32'(k), 32'd12);
        checkOutput("v99_tens", 32'(bcd_tens_o), 32'd9);
        checkOutput("v99_ones", 32'(bcd_ones_o), 32'd9);

        applyStimulus(7'd120, 1'b0);
        waitValid(k);
        checkOutput("v120_latency", 32'(k), 32'd12);
        checkOutput("v120_tens", 32'(bcd_tens_o), 32'd9);
        checkOutput("v120_ones", 32'(bcd_ones_o), 32'd9);

        applyStimulus(7'd30, 1'b0);
        tick();
        checkOutput("v30_valid_low", 32'(valid_o), 32'd0);
        applyStimulus(7'd45, 1'b0);
        tick();
        applyStimulus(7'd46, 1'b0);
        waitValid(k);
        checkOutput("v30_latency", 32'(k), 32'd4);
        checkOutput("v30_tens", 32'(bcd_tens_o), 32'd3);
        checkOutput("v30_ones", 32'(bcd_ones_o), 32'd0);
        waitValid(k);
        checkOutput("v46_latency", 32'(k), 32'd7);
        checkOutput("v46_tens", 32'(bcd_tens_o), 32'd4);
        checkOutput("v46_ones", 32'(bcd_ones_o), 32'd6);
        checkOutput("never45", 32'(seen45), 32'd0);

        applyStimulus(7'd7, 1'b0);
        waitValid(k);
        checkOutput("v7_latency", 32'(k), 32'd3);
        checkOutput("v7_tens", 32'(bcd_tens_o), 32'd0);
        checkOutput("v7_ones", 32'(bcd_ones_o), 32'd7);
        waitSelEdge(2'b10);
        checkOutput("v7_tens_seg", 32'(seg_o), 32'(expTensZero));
        waitSelEdge(2'b01);
        checkOutput("v7_ones_seg", 32'(seg_o), 32'h07);

        applyStimulus(7'd80, 1'b0);
        tick();
        tick();
        applyStimulus(7'd80, 1'b1);
        tick();
        checkOutput("midrst_valid", 32'(valid_o), 32'd0);
        checkOutput("midrst_tens", 32'(bcd_tens_o), 32'd0);
        checkOutput("midrst_ones", 32'(bcd_ones_o), 32'd0);
        checkOutput("midrst_sel", 32'(digit_sel_o), 32'h1);
        checkOutput("midrst_seg", 32'(seg_o), 32'h00);
        applyStimulus(7'd80, 1'b0);
        waitValid(k);
        checkOutput("v80_latency", 32'(k), 32'd11);
        checkOutput("v80_tens", 32'(bcd_tens_o), 32'd8);
        checkOutput("v80_ones", 32'(bcd_ones_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
